mig_app_arbiter: RTL and testbench

- Sits in the MIG clock domain between the MIG user (app) interface and two requesters.
  - Port A: display scanout prefetcher, read-only.
  - Port B: host/Wishbone bridge, read/write.
- Registers one command at a time and holds app_en/app_wdf_wren until MIG accepts.
- Arbitrates with urgency plus an anti-starvation counter.
- Tracks outstanding reads in order, so returned read data is routed to the requester that issued it.

---
 rtl/mig_app_arbiter.sv | 203 ++++++++++++++++++++
 tb/tb_mig_app_arbiter.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mig_app_arbiter.sv
// Two-port arbiter in front of the MIG app interface: urgency-aware port A reads, port B read/write,
// in-order read-data routing via an owner FIFO. Define ARB_STATS_EN to add grant/starvation statistics.
module mig_app_arbiter #(
   parameter int unsigned MIG_ADDR_WIDTH  = 30,
   parameter int unsigned DATA_WIDTH      = 128,
   parameter int unsigned MAX_OUTSTANDING = 32,
   parameter int unsigned B_MAX_WAIT      = 64
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      a_req,
   input  logic                      a_urgent,
   input  logic [MIG_ADDR_WIDTH-1:0] a_addr,
   output logic                      a_gnt,
   output logic [DATA_WIDTH-1:0]     a_rdata,
   output logic                      a_rvalid,
   input  logic                      b_req,
   input  logic                      b_we,
   input  logic [MIG_ADDR_WIDTH-1:0] b_addr,
   input  logic [DATA_WIDTH-1:0]     b_wdata,
   input  logic [DATA_WIDTH/8-1:0]   b_wbe,
   output logic                      b_gnt,
   output logic [DATA_WIDTH-1:0]     b_rdata,
   output logic                      b_rvalid,
   input  logic                      init_calib_complete,
   input  logic                      app_rdy,
   input  logic                      app_wdf_rdy,
   input  logic [DATA_WIDTH-1:0]     app_rd_data,
   input  logic                      app_rd_data_valid,
   output logic                      app_en,
   output logic [2:0]                app_cmd,
   output logic [MIG_ADDR_WIDTH-1:0] app_addr,
   output logic                      app_wdf_wren,
   output logic                      app_wdf_end,
   output logic [DATA_WIDTH-1:0]     app_wdf_data,
   output logic [DATA_WIDTH/8-1:0]   app_wdf_mask,
   output logic                      rd_owner_err
`ifdef ARB_STATS_EN
   ,
   output logic [31:0]               a_grant_cnt,
   output logic [31:0]               b_grant_cnt,
   output logic [15:0]               starve_cnt,
   output logic [7:0]                max_outstanding
`endif
);

   localparam int unsigned PTR_W  = $clog2(MAX_OUTSTANDING);
   localparam int unsigned CNT_W  = PTR_W + 1;
   localparam int unsigned WAIT_W = $clog2(B_MAX_WAIT + 1);
   localparam logic [2:0]  CMD_RD = 3'b001;
   localparam logic [2:0]  CMD_WR = 3'b000;

   typedef enum logic {IDLE, ISSUE} state_t;

   state_t                 state;
   logic [WAIT_W-1:0]      wait_cnt;
   logic [CNT_W-1:0]       outstanding;
   logic [PTR_W-1:0]       wr_ptr, rd_ptr;
   logic [MAX_OUTSTANDING-1:0] owner_mem;
   logic                   cur_owner;
   logic                   rd_room, starving, a_elig, b_elig, can_capture;
   logic                   pick_a, pick_b, push, pop;

   // Capture only happens in IDLE, where no command is in flight, so the
   // accepted-read count alone is the full in-flight figure.
   always_comb begin
      rd_room     = outstanding < CNT_W'(MAX_OUTSTANDING);
      starving    = wait_cnt >= WAIT_W'(B_MAX_WAIT);
      can_capture = !rst && init_calib_complete && (state == IDLE);
      a_elig      = a_req && rd_room;
      b_elig      = b_req && (b_we || rd_room);
      pick_a      = 1'b0;
      pick_b      = 1'b0;
      if (can_capture) begin
         if (a_elig && a_urgent)     pick_a = 1'b1;
         else if (b_elig && starving) pick_b = 1'b1;
         else if (a_elig)             pick_a = 1'b1;
         else if (b_elig)             pick_b = 1'b1;
      end
   end

   assign a_gnt       = pick_a;
   assign b_gnt       = pick_b;
   assign app_wdf_end = app_wdf_wren;
   assign push        = app_en && app_rdy && (app_cmd == CMD_RD);
   assign pop         = app_rd_data_valid && (outstanding != '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         app_en       <= 1'b0;
         app_cmd      <= CMD_RD;
         app_addr     <= '0;
         app_wdf_wren <= 1'b0;
         app_wdf_data <= '0;
         app_wdf_mask <= '0;
         cur_owner    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (pick_a) begin
                  app_en    <= 1'b1;
                  app_cmd   <= CMD_RD;
                  app_addr  <= a_addr;
                  cur_owner <= 1'b0;
                  state     <= ISSUE;
               end else if (pick_b) begin
                  app_en       <= 1'b1;
                  app_cmd      <= b_we ? CMD_WR : CMD_RD;
                  app_addr     <= b_addr;
                  app_wdf_wren <= b_we;
                  app_wdf_data <= b_wdata;
                  app_wdf_mask <= ~b_wbe;
                  cur_owner    <= 1'b1;
                  state        <= ISSUE;
               end
            end
            ISSUE: begin
               // Command and write data handshake independently; leave once both are done.
               if (app_rdy)     app_en       <= 1'b0;
               if (app_wdf_rdy) app_wdf_wren <= 1'b0;
               if ((!app_en || app_rdy) && (!app_wdf_wren || app_wdf_rdy))
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst)
         wait_cnt <= '0;
      else if (pick_b)
         wait_cnt <= '0;
      else if (b_req && (wait_cnt < WAIT_W'(B_MAX_WAIT)))
         wait_cnt <= wait_cnt + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         owner_mem   <= '0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         outstanding <= '0;
      end else begin
         if (push) begin
            owner_mem[wr_ptr] <= cur_owner;
            wr_ptr            <= wr_ptr + 1'b1;
         end
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   outstanding <= outstanding + 1'b1;
            2'b01:   outstanding <= outstanding - 1'b1;
            default: outstanding <= outstanding;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         a_rvalid     <= 1'b0;
         b_rvalid     <= 1'b0;
         a_rdata      <= '0;
         b_rdata      <= '0;
         rd_owner_err <= 1'b0;
      end else begin
         a_rvalid <= pop && !owner_mem[rd_ptr];
         b_rvalid <= pop &&  owner_mem[rd_ptr];
         if (pop) begin
            a_rdata <= app_rd_data;
            b_rdata <= app_rd_data;
         end
         if (app_rd_data_valid && (outstanding == '0))
            rd_owner_err <= 1'b1;
      end
   end

`ifdef ARB_STATS_EN
   logic starve_pick;
   logic [7:0] occ;

   always_comb begin
      starve_pick = can_capture && !(a_elig && a_urgent) && b_elig && starving;
      occ         = (32'(outstanding) > 32'd255) ? 8'hFF : 8'(outstanding);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         a_grant_cnt     <= '0;
         b_grant_cnt     <= '0;
         starve_cnt      <= '0;
         max_outstanding <= '0;
      end else begin
         if (pick_a && (a_grant_cnt != '1))     a_grant_cnt <= a_grant_cnt + 1'b1;
         if (pick_b && (b_grant_cnt != '1))     b_grant_cnt <= b_grant_cnt + 1'b1;
         if (starve_pick && (starve_cnt != '1)) starve_cnt  <= starve_cnt + 1'b1;
         if (occ > max_outstanding)             max_outstanding <= occ;
      end
   end
`endif

endmodule

// File: tb/tb_mig_app_arbiter.sv
// Randomized scoreboard bench for mig_app_arbiter: a transaction-level reference model predicts
// grants, handshakes and read routing; a separate monitor checks what the DUT presents.
module tb_mig_app_arbiter;
   localparam int AW = 30, DW = 128, MW = 16, MAXO = 32, BMW = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst, a_req, a_urgent, a_gnt, a_rvalid, b_req, b_we, b_gnt, b_rvalid;
   logic [AW-1:0] a_addr, b_addr, app_addr;
   logic [DW-1:0] a_rdata, b_rdata, b_wdata, app_rd_data, app_wdf_data;
   logic [MW-1:0] b_wbe, app_wdf_mask;
   logic calib, app_rdy, app_wdf_rdy, app_rd_data_valid;
   logic app_en, app_wdf_wren, app_wdf_end, rd_owner_err;
   logic [2:0] app_cmd;
`ifdef ARB_STATS_EN
   logic [31:0] a_grant_cnt, b_grant_cnt;
   logic [15:0] starve_cnt;
   logic [7:0]  max_outstanding;
`endif

   mig_app_arbiter #(.MIG_ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(MAXO), .B_MAX_WAIT(BMW)) dut (
      .clk(clk), .rst(rst),
      .a_req(a_req), .a_urgent(a_urgent), .a_addr(a_addr), .a_gnt(a_gnt), .a_rdata(a_rdata), .a_rvalid(a_rvalid),
      .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_wbe(b_wbe), .b_gnt(b_gnt),
      .b_rdata(b_rdata), .b_rvalid(b_rvalid),
      .init_calib_complete(calib), .app_rdy(app_rdy), .app_wdf_rdy(app_wdf_rdy),
      .app_rd_data(app_rd_data), .app_rd_data_valid(app_rd_data_valid),
      .app_en(app_en), .app_cmd(app_cmd), .app_addr(app_addr), .app_wdf_wren(app_wdf_wren),
      .app_wdf_end(app_wdf_end), .app_wdf_data(app_wdf_data), .app_wdf_mask(app_wdf_mask),
      .rd_owner_err(rd_owner_err)
`ifdef ARB_STATS_EN
      , .a_grant_cnt(a_grant_cnt), .b_grant_cnt(b_grant_cnt), .starve_cnt(starve_cnt),
      .max_outstanding(max_outstanding)
`endif
   );

   int n_cmp = 0, n_bad = 0;

   task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", nm, got, exp, $time);
      end
   endtask

   task automatic fail_now(input string nm);
      n_cmp++;
      n_bad++;
      $display("FAIL %s: got DUT output expected none at t=%0t", nm, $time);
   endtask

   typedef struct { logic [2:0] cmd; logic [AW-1:0] addr; } cmd_t;
   typedef struct { logic [DW-1:0] data; logic [MW-1:0] mask; } wd_t;
   typedef struct { bit owner; logic [DW-1:0] data; } ret_t;
   cmd_t cmd_q[$];
   wd_t  wd_q[$];
   ret_t ret_q[$];
   bit   owner_q[$];

   // Reference model state
   bit m_cmd_pend, m_data_pend, m_pend_read, m_pend_owner, m_err, m_exp_arv, m_exp_brv;
   int m_wait, m_out;

   // Stimulus knobs
   int a_rate, b_rate, rdy_rate, wrdy_rate, ret_rate, calib_cnt;
   bit rst_hold, ret_once, calib_drop_en, took_a, took_b, mon_en;

   task automatic model_reset();
      m_cmd_pend = 0; m_data_pend = 0; m_pend_read = 0; m_pend_owner = 0;
      m_err = 0; m_exp_arv = 0; m_exp_brv = 0; m_wait = 0; m_out = 0;
      cmd_q.delete(); wd_q.delete(); ret_q.delete(); owner_q.delete();
   endtask

   task automatic drive();
      rst = rst_hold;
      if (calib_cnt > 0) begin
         calib_cnt--;
         calib = 1'b0;
      end else begin
         calib = 1'b1;
         if (calib_drop_en && $urandom_range(199) == 0) calib_cnt = $urandom_range(12, 3);
      end
      if (!a_req || took_a) begin
         a_req    = ($urandom_range(99) < a_rate);
         a_addr   = AW'($urandom);
         a_urgent = ($urandom_range(3) == 0);
      end
      if (!b_req || took_b) begin
         b_req   = ($urandom_range(99) < b_rate);
         b_we    = 1'($urandom_range(1));
         b_addr  = AW'($urandom);
         b_wdata = {$urandom, $urandom, $urandom, $urandom};
         b_wbe   = MW'($urandom);
      end
      app_rdy           = ($urandom_range(99) < rdy_rate);
      app_wdf_rdy       = ($urandom_range(99) < wrdy_rate);
      app_rd_data_valid = ret_once || ((m_out > 0) && ($urandom_range(99) < ret_rate));
      app_rd_data       = {$urandom, $urandom, $urandom, $urandom};
   endtask

   task automatic step();
      bit exp_a, exp_b, a_el, b_el, can, o;
      cmd_t c;
      wd_t  w;
      ret_t r;
      chk("app_en", app_en, m_cmd_pend);
      chk("app_wdf_wren", app_wdf_wren, m_data_pend);
      chk("app_wdf_end", app_wdf_end, m_data_pend);
      chk("a_rvalid", a_rvalid, m_exp_arv);
      chk("b_rvalid", b_rvalid, m_exp_brv);
      chk("rd_owner_err", rd_owner_err, m_err);
      exp_a = 0;
      exp_b = 0;
      can  = !rst && calib && !(m_cmd_pend || m_data_pend);
      a_el = a_req && (m_out < MAXO);
      b_el = b_req && (b_we || (m_out < MAXO));
      if (can) begin
         if (a_el && a_urgent)         exp_a = 1;
         else if (b_el && m_wait >= BMW) exp_b = 1;
         else if (a_el)                exp_a = 1;
         else if (b_el)                exp_b = 1;
      end
      chk("a_gnt", a_gnt, exp_a);
      chk("b_gnt", b_gnt, exp_b);
      took_a = a_gnt;
      took_b = b_gnt;
      if (rst) begin
         model_reset();
         return;
      end
      m_exp_arv = 0;
      m_exp_brv = 0;
      if (app_rd_data_valid) begin
         if (m_out == 0) m_err = 1;
         else begin
            o = owner_q.pop_front();
            m_out--;
            if (o) m_exp_brv = 1; else m_exp_arv = 1;
            r.owner = o;
            r.data  = app_rd_data;
            ret_q.push_back(r);
         end
      end
      if (m_cmd_pend && app_rdy) begin
         m_cmd_pend = 0;
         if (m_pend_read) begin
            owner_q.push_back(m_pend_owner);
            m_out++;
         end
      end
      if (m_data_pend && app_wdf_rdy) m_data_pend = 0;
      if (exp_a) begin
         m_cmd_pend = 1; m_pend_read = 1; m_pend_owner = 0;
         c.cmd = 3'b001; c.addr = a_addr;
         cmd_q.push_back(c);
      end
      if (exp_b) begin
         m_cmd_pend = 1; m_pend_read = !b_we; m_pend_owner = 1; m_data_pend = b_we;
         c.cmd = b_we ? 3'b000 : 3'b001; c.addr = b_addr;
         cmd_q.push_back(c);
         if (b_we) begin
            w.data = b_wdata; w.mask = ~b_wbe;
            wd_q.push_back(w);
         end
      end
      if (exp_b) m_wait = 0;
      else if (b_req && m_wait < BMW) m_wait++;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         drive();
         #4;
         step();
      end
   endtask

   // Monitor: checks each presented command, write beat and read return against the queues.
   initial begin
      cmd_t c;
      wd_t  w;
      ret_t r;
      forever begin
         @(negedge clk);
         #3;
         if (mon_en && !rst) begin
            if (app_en && app_rdy) begin
               if (cmd_q.size() == 0) fail_now("cmd_unexpected");
               else begin
                  c = cmd_q.pop_front();
                  chk("app_cmd", app_cmd, c.cmd);
                  chk("app_addr", app_addr, c.addr);
               end
            end
            if (app_wdf_wren && app_wdf_rdy) begin
               if (wd_q.size() == 0) fail_now("wdata_unexpected");
               else begin
                  w = wd_q.pop_front();
                  chk("app_wdf_data", app_wdf_data, w.data);
                  chk("app_wdf_mask", app_wdf_mask, w.mask);
               end
            end
            if (a_rvalid || b_rvalid) begin
               if (ret_q.size() == 0) fail_now("rvalid_unexpected");
               else begin
                  r = ret_q.pop_front();
                  chk("rvalid_owner", b_rvalid, r.owner);
                  chk("rvalid_both", a_rvalid & b_rvalid, 1'b0);
                  chk("a_rdata", a_rdata, r.data);
                  chk("b_rdata", b_rdata, r.data);
               end
            end
         end
      end
   end

   initial begin
      rst = 1; a_req = 0; a_urgent = 0; a_addr = '0; b_req = 0; b_we = 0; b_addr = '0;
      b_wdata = '0; b_wbe = '0; calib = 0; app_rdy = 0; app_wdf_rdy = 0;
      app_rd_data = '0; app_rd_data_valid = 0;
      took_a = 0; took_b = 0; mon_en = 0; ret_once = 0;
      model_reset();
      repeat (3) @(negedge clk);
      mon_en = 1;
      #4;
      chk("rst_app_cmd", app_cmd, 3'b001);
      chk("rst_app_addr", app_addr, '0);
      chk("rst_wdf_mask", app_wdf_mask, '0);
      chk("rst_a_rdata", a_rdata, '0);

      // Reset held, then calibration low at start: requests must wait for calib.
      rst_hold = 1; calib_cnt = 6; calib_drop_en = 1;
      a_rate = 70; b_rate = 60; rdy_rate = 60; wrdy_rate = 60; ret_rate = 30;
      run(2);
      rst_hold = 0;
      run(3000);

      // No returns: fill the owner FIFO, A then blocked while B writes still pass.
      ret_rate = 0; a_rate = 90; rdy_rate = 80; wrdy_rate = 80;
      run(400);

      // One return frees one slot; that A read is then stuck in issue when reset hits.
      calib_drop_en = 0; calib_cnt = 0; b_rate = 0; a_rate = 100; rdy_rate = 100;
      run(6);
      rdy_rate = 0; ret_once = 1;
      run(1);
      ret_once = 0;
      run(4);
      rst_hold = 1;
      run(1);
      rst_hold = 0;
      run(2);
      ret_once = 1;
      run(1);
      ret_once = 0;
      run(3);
      chk("err_after_rst_return", rd_owner_err, 1'b1);

      calib_drop_en = 1; a_rate = 60; b_rate = 70; rdy_rate = 50; wrdy_rate = 40; ret_rate = 40;
      run(1000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
